// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ ports, with a credit-checked result FIFO.
// Define MULT_SCHED_SQUASH_EN to add the squash port (flush of in-flight and buffered results).
module mult_sched #(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 4,
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 6,
  parameter int RES_DEPTH = 6
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [XLEN*NUM_REQ-1:0]  req_op1,
  input  logic [XLEN*NUM_REQ-1:0]  req_op2,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     mult_reset,
  output logic                     mult_start,
  output logic [1:0]               mult_sign,
  output logic [XLEN-1:0]          mult_mcand,
  output logic [XLEN-1:0]          mult_mplier,
  input  logic [2*XLEN-1:0]        mult_product,
  input  logic                     mult_done,
  output logic                     res_valid,
  output logic [XLEN-1:0]          res_value,
  output logic [TAG_W-1:0]         res_tag,
  input  logic                     res_ready
`ifdef MULT_SCHED_SQUASH_EN
  ,
  input  logic                     squash
`endif
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(RES_DEPTH + 1);
  localparam int FPTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic squash_w;
`ifdef MULT_SCHED_SQUASH_EN
  assign squash_w = squash;
`else
  assign squash_w = 1'b0;
`endif

  logic [PTR_W-1:0]  rr_ptr_reg, grant_idx, cand_idx;
  logic              grant_found, arb_en, rst_hold_reg;
  logic [1:0]        grant_op;
  logic [XLEN-1:0]   grant_op1, grant_op2;
  logic [TAG_W-1:0]  grant_tag;
  logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next, inflight_reg, inflight_next;
  logic [CNT_W:0]    occupied;

  function automatic logic [1:0] sign_of(input logic [1:0] op);
    case (op)
      2'd2:    sign_of = 2'b01;
      2'd3:    sign_of = 2'b00;
      default: sign_of = 2'b11;
    endcase
  endfunction

  function automatic logic [FPTR_W-1:0] ptr_inc(input logic [FPTR_W-1:0] p);
    ptr_inc = (p == FPTR_W'(RES_DEPTH - 1)) ? '0 : p + FPTR_W'(1);
  endfunction

  // Registered counts only: a dequeue frees its credit for the following cycle.
  assign occupied = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  assign arb_en   = reset_n && !squash_w && (occupied < (CNT_W+1)'(RES_DEPTH));

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    req_grant   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = PTR_W'((int'(rr_ptr_reg) + 1 + i) % NUM_REQ);
      if (arb_en && !grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (grant_found) req_grant[grant_idx] = 1'b1;
  end

  assign grant_op  = req_op[int'(grant_idx)*2 +: 2];
  assign grant_op1 = req_op1[int'(grant_idx)*XLEN +: XLEN];
  assign grant_op2 = req_op2[int'(grant_idx)*XLEN +: XLEN];
  assign grant_tag = req_tag[int'(grant_idx)*TAG_W +: TAG_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg   <= PTR_W'(NUM_REQ - 1);
      rst_hold_reg <= 1'b1;
      mult_start   <= 1'b0;
      mult_sign    <= 2'b00;
      mult_mcand   <= '0;
      mult_mplier  <= '0;
    end else begin
      rst_hold_reg <= 1'b0;
      mult_start   <= grant_found;
      if (grant_found) begin
        rr_ptr_reg  <= grant_idx;
        mult_sign   <= sign_of(grant_op);
        mult_mcand  <= grant_op1;
        mult_mplier <= grant_op2;
      end
    end
  end

  // Squash resets the multiplier at the same edge the shadow pipe is cleared.
  assign mult_reset = rst_hold_reg | squash_w;

  logic [NUM_STAGE:0]             sh_valid_reg;
  logic [NUM_STAGE:0][1:0]        sh_op_reg;
  logic [NUM_STAGE:0][TAG_W-1:0]  sh_tag_reg;
  logic                           tail_valid, capture, deq;
  logic [XLEN-1:0]                tail_value;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      sh_valid_reg <= '0;
    else if (squash_w) sh_valid_reg <= '0;
    else               sh_valid_reg <= {sh_valid_reg[NUM_STAGE-1:0], grant_found};
  end

  always_ff @(posedge clock) begin
    sh_op_reg  <= {sh_op_reg[NUM_STAGE-1:0], grant_op};
    sh_tag_reg <= {sh_tag_reg[NUM_STAGE-1:0], grant_tag};
  end

  assign tail_valid = sh_valid_reg[NUM_STAGE];
  assign capture    = tail_valid && !squash_w;
  assign tail_value = (sh_op_reg[NUM_STAGE] == 2'd0) ? mult_product[XLEN-1:0]
                                                     : mult_product[2*XLEN-1:XLEN];

  logic [XLEN-1:0]   fifo_value_mem [RES_DEPTH];
  logic [TAG_W-1:0]  fifo_tag_mem   [RES_DEPTH];
  logic [FPTR_W-1:0] wr_ptr_reg, rd_ptr_reg;

  always_ff @(posedge clock) begin
    if (capture) begin
      fifo_value_mem[wr_ptr_reg] <= tail_value;
      fifo_tag_mem[wr_ptr_reg]   <= sh_tag_reg[NUM_STAGE];
    end
  end

  assign res_valid = (fifo_count_reg != '0);
  assign res_value = res_valid ? fifo_value_mem[rd_ptr_reg] : '0;
  assign res_tag   = res_valid ? fifo_tag_mem[rd_ptr_reg] : '0;
  assign deq       = res_valid && res_ready;

  always_comb begin
    fifo_count_next = fifo_count_reg;
    inflight_next   = inflight_reg;
    if (capture && !deq)      fifo_count_next = fifo_count_reg + CNT_W'(1);
    else if (!capture && deq) fifo_count_next = fifo_count_reg - CNT_W'(1);
    if (grant_found && !capture)      inflight_next = inflight_reg + CNT_W'(1);
    else if (!grant_found && capture) inflight_next = inflight_reg - CNT_W'(1);
    if (squash_w) begin
      fifo_count_next = '0;
      inflight_next   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_count_reg <= '0;
      inflight_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      fifo_count_reg <= fifo_count_next;
      inflight_reg   <= inflight_next;
      if (squash_w) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (capture) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (deq)     rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  a_done_aligned: assert property (@(posedge clock) disable iff (!reset_n)
    mult_done == tail_valid);
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(capture && !deq && fifo_count_reg == CNT_W'(RES_DEPTH)));

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a behavioural 4-stage multiplier attached.
module tb_mult_sched;
  localparam int NS = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid;
  logic [7:0]   req_op;
  logic [127:0] req_op1, req_op2;
  logic [23:0]  req_tag;
  logic [3:0]   req_grant;
  logic         mult_reset, mult_start, mult_done;
  logic [1:0]   mult_sign;
  logic [31:0]  mult_mcand, mult_mplier;
  logic [63:0]  mult_product;
  logic         res_valid, res_ready;
  logic [31:0]  res_value;
  logic [5:0]   res_tag;
`ifdef MULT_SCHED_SQUASH_EN
  logic         squash;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mult_sched dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .req_tag(req_tag), .req_grant(req_grant),
    .mult_reset(mult_reset), .mult_start(mult_start), .mult_sign(mult_sign),
    .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_product(mult_product), .mult_done(mult_done),
    .res_valid(res_valid), .res_value(res_value), .res_tag(res_tag), .res_ready(res_ready)
`ifdef MULT_SCHED_SQUASH_EN
    , .squash(squash)
`endif
  );

  // Behavioural multiplier: operands sign- or zero-extended to 64 bits per mult_sign.
  logic [63:0] mpipe_prod [NS];
  logic [NS-1:0] mpipe_v = '0;
  logic [63:0] ext_a, ext_b, model_prod;
  assign ext_a = {(mult_sign[0] ? {32{mult_mcand[31]}} : 32'h0), mult_mcand};
  assign ext_b = {(mult_sign[1] ? {32{mult_mplier[31]}} : 32'h0), mult_mplier};
  assign model_prod = ext_a * ext_b;
  assign mult_done = mpipe_v[NS-1];
  assign mult_product = mpipe_prod[NS-1];

  always @(posedge clock) begin
    if (mult_reset) mpipe_v <= '0;
    else begin
      mpipe_v <= {mpipe_v[NS-2:0], mult_start};
      mpipe_prod[0] <= model_prod;
      for (int k = 1; k < NS; k++) mpipe_prod[k] <= mpipe_prod[k-1];
    end
  end

  task automatic clear_reqs;
    req_valid = '0; req_op = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
    req_valid[p] = 1'b1;
    req_op[p*2 +: 2] = op;
    req_op1[p*32 +: 32] = a;
    req_op2[p*32 +: 32] = b;
    req_tag[p*6 +: 6] = tag;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    clear_reqs();
    res_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    res_ready = 1'b0;
    clear_reqs();
    req_valid = 4'hF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (req_grant !== 4'h0) begin bad++; $display("FAIL rst_grant got=%h exp=0", req_grant); end
    total++; if (mult_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", mult_start); end
    total++; if (mult_sign !== 2'b00) begin bad++; $display("FAIL rst_sign got=%b exp=00", mult_sign); end
    total++; if (mult_mcand !== 32'h0 || mult_mplier !== 32'h0) begin bad++; $display("FAIL rst_operands got=%h/%h exp=0", mult_mcand, mult_mplier); end
    total++; if (res_valid !== 1'b0 || res_value !== 32'h0 || res_tag !== 6'h0) begin bad++; $display("FAIL rst_result got=%b/%h/%h exp=0", res_valid, res_value, res_tag); end
    total++; if (mult_reset !== 1'b1) begin bad++; $display("FAIL rst_mult_reset got=%b exp=1", mult_reset); end
    clear_reqs();
    reset_n = 1'b1;
    #1;
    total++; if (mult_reset !== 1'b1) begin bad++; $display("FAIL rst_release_hold got=%b exp=1", mult_reset); end
    @(negedge clock);
    total++; if (mult_reset !== 1'b0) begin bad++; $display("FAIL rst_release_drop got=%b exp=0", mult_reset); end
    $display("reset: mult_reset released, outputs idle");
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    res_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      clear_reqs();
      if (c == 0) set_req(0, 2'd3, 32'hFFFF_FFFF, 32'd2, 6'd5);
      @(negedge clock);
      if (c == 0) begin
        total++; if (req_grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_grant); end
      end
      if (c == 1) begin
        total++; if (mult_start !== 1'b1 || mult_sign !== 2'b00) begin bad++; $display("FAIL single_issue got start=%b sign=%b exp 1/00", mult_start, mult_sign); end
        total++; if (mult_mcand !== 32'hFFFF_FFFF || mult_mplier !== 32'd2) begin bad++; $display("FAIL single_operands got=%h/%h exp=ffffffff/2", mult_mcand, mult_mplier); end
      end
      total++; if (res_valid !== (c == 6)) begin bad++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, res_valid, c == 6); end
      if (c == 6) begin
        total++; if (res_value !== 32'h1 || res_tag !== 6'd5) begin bad++; $display("FAIL single_result got=%h/%0d exp=1/5", res_value, res_tag); end
        $display("single MULHU: value=%h tag=%0d", res_value, res_tag);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_v [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    logic [1:0]  exp_s [3] = '{2'b11, 2'b01, 2'b11};
    res_ready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      clear_reqs();
      if (c == 0) set_req(1, 2'd1, 32'hFFFF_FFFD, 32'd5, 6'd10);
      if (c == 1) set_req(1, 2'd2, 32'hFFFF_FFFF, 32'd2, 6'd11);
      if (c == 2) set_req(1, 2'd0, 32'hFFFF_FFFD, 32'd5, 6'd12);
      @(negedge clock);
      if (c <= 2) begin
        total++; if (req_grant !== 4'b0010) begin bad++; $display("FAIL b2b_grant c=%0d got=%b exp=0010", c, req_grant); end
      end
      if (c >= 1 && c <= 3) begin
        total++; if (mult_sign !== exp_s[c-1]) begin bad++; $display("FAIL b2b_sign c=%0d got=%b exp=%b", c, mult_sign, exp_s[c-1]); end
      end
      total++; if (res_valid !== (c >= 6 && c <= 8)) begin bad++; $display("FAIL b2b_valid c=%0d got=%b", c, res_valid); end
      if (c >= 6 && c <= 8) begin
        total++;
        if (res_value !== exp_v[c-6] || res_tag !== 6'(10 + c - 6)) begin
          bad++; $display("FAIL b2b_result c=%0d got=%h/%0d exp=%h/%0d", c, res_value, res_tag, exp_v[c-6], 10 + c - 6);
        end
        $display("b2b result: value=%h tag=%0d", res_value, res_tag);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_rotate;
    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_v [5] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd10};
    logic [5:0]  exp_t [5] = '{6'd30, 6'd31, 6'd32, 6'd33, 6'd30};
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      clear_reqs();
      if (c <= 4) for (int p = 0; p < 4; p++) set_req(p, 2'd0, 32'(p + 1), 32'd10, 6'(30 + p));
      @(negedge clock);
      if (c <= 4) begin
        total++; if (req_grant !== exp_g[c]) begin bad++; $display("FAIL rotate_grant c=%0d got=%b exp=%b", c, req_grant, exp_g[c]); end
        $display("rotate: cycle %0d grant=%b", c, req_grant);
      end
      total++; if (res_valid !== (c >= 6 && c <= 10)) begin bad++; $display("FAIL rotate_valid c=%0d got=%b", c, res_valid); end
      if (c >= 6 && c <= 10) begin
        total++;
        if (res_value !== exp_v[c-6] || res_tag !== exp_t[c-6]) begin
          bad++; $display("FAIL rotate_result c=%0d got=%h/%0d exp=%h/%0d", c, res_value, res_tag, exp_v[c-6], exp_t[c-6]);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_v [7] = '{32'd3, 32'd6, 32'd9, 32'd12, 32'd3, 32'd6, 32'd9};
    logic [5:0]  exp_t [7] = '{6'd20, 6'd21, 6'd22, 6'd23, 6'd20, 6'd21, 6'd22};
    int ngrant = 0;
    int nres = 0;
    do_reset();
    res_ready = 1'b0;
    for (int p = 0; p < 4; p++) set_req(p, 2'd0, 32'(p + 1), 32'd3, 6'(20 + p));
    for (int c = 0; c <= 13; c++) begin
      @(negedge clock);
      if (req_grant != 4'h0) ngrant++;
      total++; if (!$onehot0(req_grant)) begin bad++; $display("FAIL bp_onehot c=%0d got=%b", c, req_grant); end
      if (c == 6 || c == 13) begin
        total++; if (res_valid !== 1'b1 || res_value !== 32'd3 || res_tag !== 6'd20) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/3/20", c, res_valid, res_value, res_tag); end
      end
      @(posedge clock); #1;
    end
    total++; if (ngrant != 6) begin bad++; $display("FAIL bp_grant_count got=%0d exp=6", ngrant); end
    $display("backpressure: %0d grants while stalled", ngrant);
    res_ready = 1'b1;
    for (int c = 14; c <= 40; c++) begin
      if (c == 16) clear_reqs();
      @(negedge clock);
      if (c == 14) begin
        total++; if (req_grant !== 4'h0) begin bad++; $display("FAIL bp_no_same_cycle got=%b exp=0000", req_grant); end
      end
      if (c == 15) begin
        total++; if (req_grant !== 4'b0100) begin bad++; $display("FAIL bp_resume got=%b exp=0100", req_grant); end
      end
      if (res_valid && res_ready) begin
        if (nres < 7) begin
          total++;
          if (res_value !== exp_v[nres] || res_tag !== exp_t[nres]) begin
            bad++; $display("FAIL bp_drain n=%0d got=%h/%0d exp=%h/%0d", nres, res_value, res_tag, exp_v[nres], exp_t[nres]);
          end
        end
        $display("drain: value=%h tag=%0d", res_value, res_tag);
        nres++;
      end
      @(posedge clock); #1;
    end
    total++; if (nres != 7) begin bad++; $display("FAIL bp_drain_count got=%0d exp=7", nres); end
  endtask

  task automatic test_async_reset;
    int stale = 0;
    do_reset();
    res_ready = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      clear_reqs();
      if (c <= 3 || c == 6) set_req(0, 2'd0, 32'(c + 1), 32'd2, 6'(50 + c));
      @(posedge clock); #1;
    end
    set_req(0, 2'd0, 32'd9, 32'd2, 6'd57);
    #2;
    total++; if (res_valid !== 1'b1 || req_grant !== 4'b0001 || mult_start !== 1'b1) begin bad++; $display("FAIL arst_before got=%b/%b/%b exp=1/0001/1", res_valid, req_grant, mult_start); end
    reset_n = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0 || res_value !== 32'h0 || res_tag !== 6'h0) begin bad++; $display("FAIL arst_result got=%b/%h/%h exp=0", res_valid, res_value, res_tag); end
    total++; if (req_grant !== 4'h0 || mult_start !== 1'b0 || mult_mcand !== 32'h0 || mult_reset !== 1'b1) begin bad++; $display("FAIL arst_issue got=%b/%b/%h/%b exp=0000/0/0/1", req_grant, mult_start, mult_mcand, mult_reset); end
    clear_reqs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (res_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL arst_stale got=%0d exp=0", stale); end
    $display("async reset: %0d stale results after release", stale);
    @(posedge clock); #1;
  endtask

`ifdef MULT_SCHED_SQUASH_EN
  task automatic test_squash;
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      clear_reqs();
      squash = 1'b0;
      if (c < 3) set_req(0, 2'd0, 32'(c + 2), 32'd3, 6'(33 + c));
      if (c == 3) begin squash = 1'b1; set_req(0, 2'd0, 32'd9, 32'd9, 6'd39); end
      if (c == 4) set_req(0, 2'd0, 32'd7, 32'd6, 6'd40);
      @(negedge clock);
      if (c == 3) begin
        total++; if (req_grant !== 4'h0 || mult_reset !== 1'b1) begin bad++; $display("FAIL squash_cycle got=%b/%b exp=0000/1", req_grant, mult_reset); end
      end
      if (c == 4) begin
        total++; if (req_grant !== 4'b0001 || mult_reset !== 1'b0) begin bad++; $display("FAIL squash_resume got=%b/%b exp=0001/0", req_grant, mult_reset); end
      end
      total++; if (res_valid !== (c == 10)) begin bad++; $display("FAIL squash_valid c=%0d got=%b", c, res_valid); end
      if (c == 10) begin
        total++; if (res_value !== 32'd42 || res_tag !== 6'd40) begin bad++; $display("FAIL squash_result got=%h/%0d exp=2a/40", res_value, res_tag); end
        $display("squash: post-squash result value=%h tag=%0d", res_value, res_tag);
      end
      @(posedge clock); #1;
    end
    squash = 1'b0;
  endtask
`endif

  initial begin
    clear_reqs();
    res_ready = 1'b0;
`ifdef MULT_SCHED_SQUASH_EN
    squash = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_rotate();
    test_backpressure();
    test_async_reset();
`ifdef MULT_SCHED_SQUASH_EN
    test_squash();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
